mac_9_bist_ctrl: RTL

//  On-fabric stimulus/checker stage wrapped around the mac_9 benchmark. Feeds it pseudo-random a/b/c

---
 rtl/mac_9_bist_pkg.sv | 21 ++
 rtl/mac_9_bist_lfsr.sv | 28 ++
 rtl/mac_9_bist_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mac_9_bist_pkg.sv
// Shared types and constants for the mac_9 BIST controller.
// The LFSR step lives here so the generator and any future checker agree on the polynomial.
package mac_9_bist_pkg;

    typedef logic [1:0] bist_state_t;

    localparam bist_state_t StIdle  = 2'd0;
    localparam bist_state_t StRun   = 2'd1;
    localparam bist_state_t StDrain = 2'd2;
    localparam bist_state_t StDone  = 2'd3;

    localparam int unsigned       LFSR_W    = 27;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 27'h4000013;
    localparam logic [15:0]       ERR_SAT   = 16'hFFFF;

    // Fibonacci form of x^27+x^5+x^2+x+1, shifting toward the MSB.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mac_9_bist_lfsr.sv
// Vector-source LFSR for the mac_9 BIST controller.
// seed is expected to be a static constant; an all-zero seed would lock up, so it becomes 1.
module mac_9_bist_lfsr
    import mac_9_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] seed_safe;

    assign seed_safe = (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= seed_safe;
        end else if (load) begin
            state <= seed_safe;
        end else if (en) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/mac_9_bist_ctrl.sv
// Synthesizable stimulus/checker wrapped around the mac_9 multiply-add.
// Drives LFSR vectors, delays the golden result by LATENCY and counts mismatches.
module mac_9_bist_ctrl
    import mac_9_bist_pkg::*;
#(
    parameter int unsigned       WIDTH       = 9,
    parameter int unsigned       LATENCY     = 1,
    parameter int unsigned       NUM_VECTORS = 1024,
    parameter logic [LFSR_W-1:0] SEED        = 27'h0ACE5ED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] c_o,
    input  logic [WIDTH-1:0] dut_out_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      first_err
);

    localparam logic [15:0] NumVec    = 16'(NUM_VECTORS);
    localparam logic [2:0]  DrainLast = 3'(LATENCY == 0 ? 0 : LATENCY - 1);

    bist_state_t       state_q, state_d;
    logic [15:0]       vec_cnt_q, issue_idx;
    logic [2:0]        drain_cnt_q;
    logic [LFSR_W-1:0] lfsr_state;
    logic              go, issue, last_issue;
    logic              drv_valid_q;
    logic [15:0]       drv_idx_q;
    logic [WIDTH-1:0]  exp_now;
    logic              tail_valid, mismatch;
    logic [WIDTH-1:0]  tail_exp;
    logic [15:0]       tail_idx;
    logic [15:0]       err_q, first_q;

    assign go         = start && (state_q == StIdle || state_q == StDone);
    assign issue      = go || (state_q == StRun && vec_cnt_q != NumVec);
    assign issue_idx  = go ? 16'd0 : vec_cnt_q;
    assign last_issue = issue && (issue_idx == NumVec - 16'd1);

    // Reloading on the final issue leaves the LFSR at SEED for the next start.
    mac_9_bist_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (last_issue),
        .en    (issue),
        .seed  (SEED),
        .state (lfsr_state)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: if (start) state_d = StRun;
            StRun: begin
                if (vec_cnt_q == NumVec) state_d = (LATENCY == 0) ? StDone : StDrain;
            end
            StDrain: if (drain_cnt_q == DrainLast) state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            vec_cnt_q   <= '0;
            drain_cnt_q <= '0;
            drv_valid_q <= 1'b0;
            drv_idx_q   <= '0;
            a_o         <= '0;
            b_o         <= '0;
            c_o         <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= (state_q == StDrain) ? drain_cnt_q + 3'd1 : 3'd0;
            drv_valid_q <= issue;
            if (issue) begin
                vec_cnt_q <= issue_idx + 16'd1;
                drv_idx_q <= issue_idx;
                a_o       <= lfsr_state[3*WIDTH-1:2*WIDTH];
                b_o       <= lfsr_state[2*WIDTH-1:WIDTH];
                c_o       <= lfsr_state[WIDTH-1:0];
            end
        end
    end

    // Low WIDTH bits of the full product depend only on the low operand bits.
    assign exp_now = a_o * b_o + c_o;

    generate
        if (LATENCY == 0) begin : g_comb
            assign tail_valid = drv_valid_q;
            assign tail_exp   = exp_now;
            assign tail_idx   = drv_idx_q;
        end else begin : g_pipe
            logic [LATENCY-1:0] vld_q;
            logic [WIDTH-1:0]   exp_q [LATENCY];
            logic [15:0]        idx_q [LATENCY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < LATENCY; i++) begin
                        exp_q[i] <= '0;
                        idx_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= drv_valid_q;
                    exp_q[0] <= exp_now;
                    idx_q[0] <= drv_idx_q;
                    for (int i = 1; i < LATENCY; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        exp_q[i] <= exp_q[i-1];
                        idx_q[i] <= idx_q[i-1];
                    end
                end
            end

            assign tail_valid = vld_q[LATENCY-1];
            assign tail_exp   = exp_q[LATENCY-1];
            assign tail_idx   = idx_q[LATENCY-1];
        end
    endgenerate

    assign mismatch = tail_valid && (dut_out_i != tail_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q   <= '0;
            first_q <= ERR_SAT;
        end else if (go) begin
            err_q   <= '0;
            first_q <= ERR_SAT;
        end else if (mismatch) begin
            if (err_q != ERR_SAT) err_q <= err_q + 16'd1;
            if (first_q == ERR_SAT) first_q <= tail_idx;
        end
    end

    assign busy      = (state_q == StRun) || (state_q == StDrain);
    assign done      = (state_q == StDone);
    assign pass      = done && (err_q == 16'd0);
    assign err_count = err_q;
    assign first_err = first_q;

endmodule
